// File: rtl/sd_blk_arb.sv
// sd_blk_arb: shares the host block-level SD port between the SDC (client A) and floppy (client B)
// controllers, forwarding one request at a time and steering ack/buffer traffic to the owner only.
module sd_blk_arb #(
    parameter int unsigned TIMEOUT_W = 24
) (
    input  logic        clock,
    input  logic        RESET_N,
    input  logic [31:0] a_lba [2],
    input  logic [1:0]  a_rd,
    input  logic [1:0]  a_wr,
    output logic [1:0]  a_ack,
    output logic        a_buff_wr,
    input  logic [7:0]  a_buff_din [2],
    input  logic [31:0] b_lba [2],
    input  logic [1:0]  b_rd,
    input  logic [1:0]  b_wr,
    output logic [1:0]  b_ack,
    output logic        b_buff_wr,
    input  logic [7:0]  b_buff_din [2],
    output logic [31:0] sd_lba [2],
    output logic [1:0]  sd_rd,
    output logic [1:0]  sd_wr,
    input  logic [1:0]  sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din [2],
    output logic        arb_busy,
    output logic        arb_owner,
    output logic        arb_timeout
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, XFER, RELEASE} state_t;

    state_t               state;
    logic                 owner;
    logic                 last_owner;
    logic                 drv;
    logic                 op;
    logic [TIMEOUT_W-1:0] wdog;

    logic                 pend_a;
    logic                 pend_b;
    logic                 pick_b;
    logic [1:0]           rd_pick;
    logic [1:0]           req_pick;
    logic                 drv_pick;
    logic [31:0]          lba_pick;
    logic [1:0]           rd_own;
    logic [1:0]           wr_own;
    logic [1:0]           drv_mask;
    logic                 fwd;
    logic [TIMEOUT_W-1:0] wdog_nxt;

    always_comb begin
        pend_a   = |(a_rd | a_wr);
        pend_b   = |(b_rd | b_wr);
        // On a tie the client that did not own the last completed grant wins.
        pick_b   = pend_b && (!pend_a || !last_owner);
        rd_pick  = pick_b ? b_rd : a_rd;
        req_pick = rd_pick | (pick_b ? b_wr : a_wr);
        drv_pick = !req_pick[0];
        lba_pick = pick_b ? b_lba[drv_pick] : a_lba[drv_pick];
        rd_own   = owner ? b_rd : a_rd;
        wr_own   = owner ? b_wr : a_wr;
        drv_mask = drv ? 2'b10 : 2'b01;
        fwd      = (state == WAIT_ACK) || (state == XFER);
        wdog_nxt = wdog + TIMEOUT_W'(1);
    end

    assign a_ack     = (fwd && !owner) ? (sd_ack & drv_mask) : '0;
    assign b_ack     = (fwd && owner) ? (sd_ack & drv_mask) : '0;
    assign a_buff_wr = fwd && !owner && sd_buff_wr;
    assign b_buff_wr = fwd && owner && sd_buff_wr;
    assign arb_busy  = (state != IDLE);
    assign arb_owner = owner;

    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            sd_buff_din[i] = (arb_busy && owner) ? b_buff_din[i] : a_buff_din[i];
        end
    end

    always_ff @(posedge clock or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_owner  <= 1'b1;
            drv         <= 1'b0;
            op          <= 1'b0;
            wdog        <= '0;
            sd_rd       <= '0;
            sd_wr       <= '0;
            sd_lba[0]   <= '0;
            sd_lba[1]   <= '0;
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        owner            <= pick_b;
                        drv              <= drv_pick;
                        op               <= rd_pick[drv_pick];
                        sd_lba[drv_pick] <= lba_pick;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    sd_rd <= op ? drv_mask : '0;
                    sd_wr <= op ? '0 : drv_mask;
                    wdog  <= '0;
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    wdog <= wdog_nxt;
                    // Ack takes priority over a simultaneous cancel or timeout.
                    if (sd_ack[drv]) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= XFER;
                    end else if (!rd_own[drv] && !wr_own[drv]) begin
                        sd_rd <= '0;
                        sd_wr <= '0;
                        state <= IDLE;
                    end else if (&wdog_nxt) begin
                        sd_rd       <= '0;
                        sd_wr       <= '0;
                        arb_timeout <= 1'b1;
                        state       <= IDLE;
                    end
                end
                XFER: begin
                    if (!sd_ack[drv]) state <= RELEASE;
                end
                RELEASE: begin
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
